// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   - default parameter values
//   - controller state encoding (RUN=0, MEM_WAIT=1, HALTED=2)
//   - ctrl_t: packed bundle of the eight stage-register controls
//   - apply_hazards(): overlays load-use / branch handling on an advancing cycle
package pipe_hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_W  = 5;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_TO_W        = 7;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_e;

  // Bit order (MSB first): pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
  // if_id_flush, id_ex_flush, mem_wb_flush.
  typedef struct packed {
    logic pc_le;
    logic if_id_le;
    logic id_ex_le;
    logic ex_mem_le;
    logic mem_wb_le;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = 8'b0000_0000;
  localparam ctrl_t CTRL_RUN    = 8'b1111_1000;
  // Memory freeze: front four stages hold, MEM/WB keeps clocking but is
  // cleared so the instruction already in WB retires exactly once.
  localparam ctrl_t CTRL_FREEZE = 8'b0000_1001;

  // Load-use wins over a taken branch: the branch operands may depend on the
  // load, so the branch is simply re-evaluated after the bubble.
  function automatic ctrl_t apply_hazards(input ctrl_t base,
                                          input logic  load_use,
                                          input logic  branch_taken);
    ctrl_t c;
    c = base;
    if (load_use) begin
      c.pc_le       = 1'b0;
      c.if_id_le    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-information / stage-control bundle between the pipeline datapath
// and the hazard controller.
//   master : pipeline side, drives hazard information, receives controls
//   slave  : controller side, reads hazard information, drives controls
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

  // hazard information from the datapath
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_reg_dest;
  logic                  branch_taken;
  logic                  dmem_req;
  logic                  dmem_ack;
  logic                  halt_wb;

  // stage-register controls back to the datapath
  logic pc_load_en;
  logic if_id_load_en;
  logic id_ex_load_en;
  logic ex_mem_load_en;
  logic mem_wb_load_en;
  logic if_id_flush;
  logic id_ex_flush;
  logic mem_wb_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_dest,
           branch_taken, dmem_req, dmem_ack, halt_wb,
    input  pc_load_en, if_id_load_en, id_ex_load_en, ex_mem_load_en,
           mem_wb_load_en, if_id_flush, id_ex_flush, mem_wb_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_reg_dest,
           branch_taken, dmem_req, dmem_ack, halt_wb,
    output pc_load_en, if_id_load_en, id_ex_load_en, ex_mem_load_en,
           mem_wb_load_en, if_id_flush, id_ex_flush, mem_wb_flush
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   inc_i      : count this cycle
//   count_o    : current value, sticks at all-ones
module pipe_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for a 5-stage MIPS pipeline.
// Priority: data-memory wait (with timeout) > load-use bubble > taken-branch
// squash. Also handles halt-in-WB and two saturating performance counters.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bus (slave)      : hazard inputs and stage-register load/flush outputs
//   halted_o         : controller is in HALTED
//   mem_error_o      : sticky data-memory timeout flag
//   stall_cycles_o   : cycles with pc_load_en=0 outside HALTED (saturating)
//   flush_count_o    : cycles with if_id_flush=1 (saturating)
// Stage controls are Mealy outputs: combinational from state and the
// same-cycle inputs, forced inactive while reset is asserted.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_hazard_ctrl_if.slave bus,
  output logic             halted_o,
  output logic             mem_error_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;
  localparam logic [TO_W-1:0]       WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_error_q, mem_error_d;

  logic  load_use;
  ctrl_t adv_ctrl;
  ctrl_t ctrl;
  ctrl_t ctrl_out;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = bus.ex_mem_read && (bus.ex_reg_dest != ZERO_REG) &&
                    ((bus.ex_reg_dest == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_reg_dest == bus.id_rt)));

  // Controls for a cycle in which the pipeline is allowed to advance.
  assign adv_ctrl = apply_hazards(CTRL_RUN, load_use, bus.branch_taken);

  always_comb begin
    ctrl        = CTRL_IDLE;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      ST_RUN: begin
        if (bus.dmem_req && !bus.dmem_ack) begin
          // Memory stall outranks everything; halt_wb is not acted on
          // because nothing retires into a fresh state this cycle.
          ctrl       = CTRL_FREEZE;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = TO_W'(1);
        end else begin
          ctrl = adv_ctrl;
          if (bus.halt_wb) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ack) begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + TO_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            mem_error_d = 1'b1;
            state_d     = ST_HALTED;
            wait_cnt_d  = '0;
          end
        end else begin
          // Ack releases the freeze; this cycle behaves like a plain RUN
          // cycle, including on the would-be timeout cycle.
          ctrl       = adv_ctrl;
          wait_cnt_d = '0;
          state_d    = bus.halt_wb ? ST_HALTED : ST_RUN;
        end
      end
      ST_HALTED: begin
        ctrl = CTRL_IDLE;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Keep every stage register idle while reset is held.
  assign ctrl_out = rst_n ? ctrl : CTRL_IDLE;

  assign bus.pc_load_en     = ctrl_out.pc_le;
  assign bus.if_id_load_en  = ctrl_out.if_id_le;
  assign bus.id_ex_load_en  = ctrl_out.id_ex_le;
  assign bus.ex_mem_load_en = ctrl_out.ex_mem_le;
  assign bus.mem_wb_load_en = ctrl_out.mem_wb_le;
  assign bus.if_id_flush    = ctrl_out.if_id_flush;
  assign bus.id_ex_flush    = ctrl_out.id_ex_flush;
  assign bus.mem_wb_flush   = ctrl_out.mem_wb_flush;

  assign halted_o    = (state_q == ST_HALTED);
  assign mem_error_o = mem_error_q;

  // Counter 0: stall cycles, counter 1: IF/ID flushes.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign cnt_inc[0] = !ctrl.pc_le && (state_q != ST_HALTED);
  assign cnt_inc[1] = ctrl.if_id_flush;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      pipe_hazard_ctrl_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (cnt_inc[gi]),
        .count_o (cnt_val[gi])
      );
    end
  endgenerate

  assign stall_cycles_o = cnt_val[0];
  assign flush_count_o  = cnt_val[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Counter expectations in the table are the values before that cycle's edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 3;

  // control vector order: pc, if_id, id_ex, ex_mem, mem_wb load_en,
  //                       if_id_flush, id_ex_flush, mem_wb_flush
  localparam logic [7:0] C_RUN  = 8'hF8;
  localparam logic [7:0] C_LU   = 8'h3A;
  localparam logic [7:0] C_BR   = 8'hFC;
  localparam logic [7:0] C_FRZ  = 8'h09;
  localparam logic [7:0] C_HALT = 8'h00;
  localparam logic [7:0] ALL    = 8'hFF;
  localparam logic [7:0] NO_MWL = 8'hF7; // mem_wb_load_en is don't-care while flushed

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) bus();

  logic             halted, mem_error;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(
    .REG_ADDR_W  (5),
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (4),
    .TO_W        (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .halted_o       (halted),
    .mem_error_o    (mem_error),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [4:0] rs, rt;
    logic       uses_rt, mem_read;
    logic [4:0] dest;
    logic       br, req, ack, halt;
    logic [7:0] exp_ctrl, care;
    logic       exp_halted, exp_err;
    logic [2:0] exp_stall, exp_flush;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic mem_read,
                              input logic [4:0] dest, input logic br,
                              input logic req, input logic ack, input logic halt,
                              input logic [7:0] ec, input logic [7:0] care,
                              input logic eh, input logic ee,
                              input logic [2:0] es, input logic [2:0] ef);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mem_read = mem_read;
    v.dest = dest; v.br = br; v.req = req; v.ack = ack; v.halt = halt;
    v.exp_ctrl = ec; v.care = care; v.exp_halted = eh; v.exp_err = ee;
    v.exp_stall = es; v.exp_flush = ef;
    return v;
  endfunction

  function automatic logic [7:0] ctrl_now();
    return {bus.pc_load_en, bus.if_id_load_en, bus.id_ex_load_en,
            bus.ex_mem_load_en, bus.mem_wb_load_en,
            bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush};
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic check_all(input string nm, input int idx,
                           input logic [7:0] ec, input logic [7:0] care,
                           input logic eh, input logic ee,
                           input logic [2:0] es, input logic [2:0] ef);
    chk({nm, ".ctrl"},   idx, ctrl_now() & care, ec & care);
    chk({nm, ".halted"}, idx, {7'd0, halted},    {7'd0, eh});
    chk({nm, ".memerr"}, idx, {7'd0, mem_error}, {7'd0, ee});
    chk({nm, ".stall"},  idx, {5'd0, stall_cycles}, {5'd0, es});
    chk({nm, ".flush"},  idx, {5'd0, flush_count},  {5'd0, ef});
  endtask

  task automatic drive(input vec_t v);
    bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt;
    bus.ex_mem_read = v.mem_read; bus.ex_reg_dest = v.dest;
    bus.branch_taken = v.br; bus.dmem_req = v.req; bus.dmem_ack = v.ack;
    bus.halt_wb = v.halt;
  endtask

  task automatic set_idle();
    drive(mk(5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0, C_RUN, ALL, 0, 0, 3'd0, 3'd0));
  endtask

  // Assert reset for one cycle, check the reset values, then release.
  task automatic do_reset(input int idx);
    @(negedge clk);
    rst_n = 1'b0;
    set_idle();
    #1;
    check_all("reset", idx, C_HALT, ALL, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //           rs  rt uses mrd dest br req ack hlt  ctrl    care   h  e  stall flush
    vecs[0]  = mk(1,  2, 0,  0,  0,   0, 0,  0,  0,  C_RUN,  ALL,   0, 0, 0, 0); // plain run
    vecs[1]  = mk(8,  2, 0,  1,  8,   0, 0,  0,  0,  C_LU,   ALL,   0, 0, 0, 0); // load-use on rs
    vecs[2]  = mk(8,  2, 0,  1,  0,   0, 0,  0,  0,  C_RUN,  ALL,   0, 0, 1, 0); // dest=0: no hazard
    vecs[3]  = mk(1,  2, 0,  0,  0,   1, 0,  0,  0,  C_BR,   ALL,   0, 0, 1, 0); // taken branch
    vecs[4]  = mk(1,  9, 1,  1,  9,   1, 0,  0,  0,  C_LU,   ALL,   0, 0, 1, 1); // load-use on rt beats branch
    vecs[5]  = mk(1,  9, 0,  1,  9,   1, 0,  0,  0,  C_BR,   ALL,   0, 0, 2, 1); // rt unused: branch only
    vecs[6]  = mk(1,  2, 0,  0,  0,   0, 1,  1,  0,  C_RUN,  ALL,   0, 0, 2, 2); // same-cycle ack
    vecs[7]  = mk(8,  2, 0,  1,  8,   1, 1,  0,  1,  C_FRZ,  NO_MWL,0, 0, 2, 2); // freeze, others ignored
    vecs[8]  = mk(1,  2, 0,  0,  0,   0, 1,  0,  0,  C_FRZ,  NO_MWL,0, 0, 3, 2); // wait_cnt 1
    vecs[9]  = mk(1,  2, 0,  0,  0,   0, 1,  0,  0,  C_FRZ,  NO_MWL,0, 0, 4, 2); // wait_cnt 2
    vecs[10] = mk(1,  2, 0,  0,  0,   1, 1,  1,  0,  C_BR,   ALL,   0, 0, 5, 2); // ack on timeout cycle
    vecs[11] = mk(1,  2, 0,  0,  0,   0, 0,  0,  0,  C_RUN,  ALL,   0, 0, 5, 3); // back in RUN, no error
    vecs[12] = mk(1,  2, 0,  0,  0,   0, 0,  0,  1,  C_RUN,  ALL,   0, 0, 5, 3); // halt in WB
    vecs[13] = mk(8,  2, 0,  1,  8,   1, 1,  0,  0,  C_HALT, ALL,   1, 0, 5, 3); // halted ignores inputs
    vecs[14] = mk(1,  2, 0,  0,  0,   0, 0,  0,  0,  C_HALT, ALL,   1, 0, 5, 3); // stays halted

    set_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset", 0, C_HALT, ALL, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      #1;
      check_all("vec", i, vecs[i].exp_ctrl, vecs[i].care, vecs[i].exp_halted,
                vecs[i].exp_err, vecs[i].exp_stall, vecs[i].exp_flush);
      @(negedge clk);
    end

    // Timeout: four frozen cycles without ack, then halted with error.
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      bus.dmem_req = 1'b1;
      bus.dmem_ack = 1'b0;
      #1;
      chk("timeout.ctrl", k, ctrl_now() & NO_MWL, C_FRZ & NO_MWL);
      chk("timeout.halted", k, {7'd0, halted}, 8'd0);
      @(negedge clk);
    end
    #1;
    check_all("timeout.end", 0, C_HALT, ALL, 1'b1, 1'b1, 3'd4, 3'd0);

    // Reset in the middle of a memory wait.
    do_reset(2);
    bus.dmem_req = 1'b1;
    bus.dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all("midwait", 0, C_FRZ, NO_MWL, 1'b0, 1'b0, 3'd2, 3'd0);
    rst_n = 1'b0;
    #1;
    check_all("midwait.rst", 0, C_HALT, ALL, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    check_all("midwait.rst", 1, C_HALT, ALL, 1'b0, 1'b0, 3'd0, 3'd0);
    rst_n = 1'b1;
    set_idle();
    #1;
    check_all("midwait.run", 0, C_RUN, ALL, 1'b0, 1'b0, 3'd0, 3'd0);
    @(negedge clk);

    // Saturation: 9 load-use stalls, then 9 branch flushes; both cap at 7.
    do_reset(3);
    for (int k = 0; k < 9; k++) begin
      drive(mk(5'd8, 5'd2, 0, 1, 5'd8, 0, 0, 0, 0, C_LU, ALL, 0, 0, 3'd0, 3'd0));
      @(negedge clk);
    end
    set_idle();
    #1;
    check_all("sat.stall", 0, C_RUN, ALL, 1'b0, 1'b0, 3'd7, 3'd0);
    for (int k = 0; k < 9; k++) begin
      drive(mk(5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, C_BR, ALL, 0, 0, 3'd0, 3'd0));
      @(negedge clk);
    end
    set_idle();
    #1;
    check_all("sat.flush", 0, C_RUN, ALL, 1'b0, 1'b0, 3'd7, 3'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
